// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM bus bundle between a CPU bus master and avalon_ram_slave.
// Handshake: the master holds address/read/write/byteenable/writedata stable while waitrequest is high; a transfer completes in the cycle where a request is present and waitrequest is low, and readdata is valid only in that cycle.
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave RAM with a data region at 0 and a boot region at BOOT_BASE,
// programmable/pseudo-random wait states, sticky error flag and transfer counter.
module avalon_ram_slave #(
    parameter int unsigned DATA_WORDS  = 2048,
    parameter logic [31:0] BOOT_BASE   = 32'hBFC00000,
    parameter int unsigned BOOT_WORDS  = 512,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RANDOM_WAIT = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                     clk,
    input  logic                     reset,
    avalon_ram_slave_if.slave        bus,
    output logic                     err,
    output logic [15:0]              xfer_count,
    output logic                     o_dbg_state
);

    localparam int unsigned DATA_AW    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int unsigned BOOT_AW    = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;
    localparam logic [32:0] DATA_BYTES = 33'(DATA_WORDS) * 33'd4;
    localparam logic [32:0] BOOT_BYTES = 33'(BOOT_WORDS) * 33'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [31:0] r_data_mem [DATA_WORDS];
    logic [31:0] r_boot_mem [BOOT_WORDS];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [7:0]  r_lfsr;
    logic        r_live;
    logic        r_err;
    logic [15:0] r_count;

    logic [31:0]        w_boot_off;
    logic               w_data_hit;
    logic               w_boot_hit;
    logic [DATA_AW-1:0] w_data_idx;
    logic [BOOT_AW-1:0] w_boot_idx;
    logic [31:0]        w_word;
    logic [3:0]         w_n;
    logic               w_lfsr_fb;
    logic               w_changed;
    logic               w_wait;
    logic               w_done;
    logic               w_latch;
    logic               w_lfsr_step;
    logic               w_err_set;
    logic               w_commit;

    // Address decode; low two address bits are ignored for indexing.
    assign w_boot_off = bus.address - BOOT_BASE;
    assign w_data_hit = ({1'b0, bus.address} < DATA_BYTES);
    assign w_boot_hit = (bus.address >= BOOT_BASE) && ({1'b0, w_boot_off} < BOOT_BYTES);
    assign w_data_idx = bus.address[DATA_AW+1:2];
    assign w_boot_idx = w_boot_off[BOOT_AW+1:2];

    always_comb begin
        w_word = 32'h0;
        if (w_data_hit) begin
            w_word = r_data_mem[w_data_idx];
        end else if (w_boot_hit) begin
            w_word = r_boot_mem[w_boot_idx];
        end
    end

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_n       = (RANDOM_WAIT != 0) ? {2'b00, r_lfsr[1:0]} : 4'(WAIT_CYCLES);
    assign w_changed = (bus.address != r_addr) || (bus.read != r_rd) || (bus.write != r_wr);

    // r_live keeps every output at its reset value until the first edge after reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait      = 1'b0;
        w_done      = 1'b0;
        w_latch     = 1'b0;
        w_lfsr_step = 1'b0;
        w_err_set   = 1'b0;
        if (r_live) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.read && bus.write) begin
                        w_done = 1'b1;
                    end else if (bus.read || bus.write) begin
                        w_lfsr_step = 1'b1;
                        if (w_n == 4'd0) begin
                            w_done = 1'b1;
                        end else begin
                            w_wait      = 1'b1;
                            w_cnt_nxt   = w_n - 4'd1;
                            w_latch     = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.read && !bus.write) begin
                        w_err_set   = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end else if (w_changed) begin
                        // Master broke the hold rule: restart the stall from IDLE next cycle.
                        w_wait      = 1'b1;
                        w_err_set   = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        w_wait    = 1'b1;
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
            if (w_done && ((bus.read && bus.write) || (bus.address[1:0] != 2'b00)
                           || (!w_data_hit && !w_boot_hit))) begin
                w_err_set = 1'b1;
            end
        end
    end

    assign w_commit        = w_done && bus.write && !bus.read;
    assign bus.waitrequest = w_wait;
    assign bus.readdata    = (w_done && bus.read && !bus.write) ? w_word : 32'h0;
    assign err             = r_err;
    assign xfer_count      = r_count;
    assign o_dbg_state     = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_lfsr  <= 8'h5A;
            r_live  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= 16'h0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr <= bus.address;
                r_rd   <= bus.read;
                r_wr   <= bus.write;
            end
            if (w_lfsr_step) begin
                r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    // Storage has no reset; a write is only committed at its completing edge.
    always_ff @(posedge clk) begin
        if (w_commit && w_data_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    r_data_mem[w_data_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
        if (w_commit && w_boot_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    r_boot_mem[w_boot_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: four instances (0, 3, 5 and random wait states)
// share one stimulus port selected by sel; a monitor checks completions against a queue.
`timescale 1ns/1ps
module tb_avalon_ram_slave;

    localparam int          N_DUT = 4;
    localparam int          WC   [N_DUT] = '{0, 3, 5, 0};
    localparam int          SMIN [N_DUT] = '{0, 3, 5, 0};
    localparam int          SMAX [N_DUT] = '{0, 3, 5, 3};
    localparam logic [31:0] BOOT = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] writedata = 32'h0;
    logic [1:0]  sel = 2'd0;

    logic [N_DUT-1:0] wait_v;
    logic [N_DUT-1:0] err_v;
    logic [N_DUT-1:0] dbg_v;
    logic [31:0]      rdat_v [N_DUT];
    logic [15:0]      xc_v   [N_DUT];
    logic             m_wait;
    logic [31:0]      m_rdata;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N_DUT; k++) begin : g_dut
        avalon_ram_slave_if bus ();
        assign bus.address    = address;
        assign bus.read       = read && (sel == 2'(k));
        assign bus.write      = write && (sel == 2'(k));
        assign bus.byteenable = byteenable;
        assign bus.writedata  = writedata;
        assign wait_v[k]      = bus.waitrequest;
        assign rdat_v[k]      = bus.readdata;

        avalon_ram_slave #(
            .WAIT_CYCLES (WC[k]),
            .RANDOM_WAIT ((k == 3) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .bus         (bus),
            .err         (err_v[k]),
            .xfer_count  (xc_v[k]),
            .o_dbg_state (dbg_v[k])
        );
    end

    assign m_wait  = wait_v[sel];
    assign m_rdata = rdat_v[sel];

    // Reference model: word store keyed by (instance, aligned address), counts and error flags.
    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          smin;
        int          smax;
    } exp_t;

    logic [31:0] mem_m [longint];
    int          cnt_m [N_DUT];
    bit          err_m [N_DUT];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stall = 0;

    function automatic bit hit_m(input logic [31:0] a);
        return (a < 32'd8192) || ((a >= BOOT) && ((a - BOOT) < 32'd2048));
    endfunction

    function automatic longint key_m(input int k, input logic [31:0] a);
        longint key;
        key = {32'(k), a[31:2], 2'b00};
        return key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks every completed transfer.
    always @(negedge clk) begin
        if (!reset) begin
            stall = 0;
        end else if (read || write) begin
            if (m_wait) begin
                stall++;
            end else begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_completion: addr %h with no expected entry", address);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_cmp++;
                    if (stall < mon_e.smin || stall > mon_e.smax) begin
                        n_fail++;
                        $display("FAIL stall_len: addr %h got %0d cycles expected %0d..%0d",
                                 address, stall, mon_e.smin, mon_e.smax);
                    end
                    if (mon_e.is_rd) begin
                        check($sformatf("readdata@%h", address), m_rdata, mon_e.data);
                    end
                end
                stall = 0;
            end
        end
    end

    task automatic do_xfer(input int k, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] word;
        longint      key;
        int          budget;
        key     = key_m(k, a);
        e.is_rd = rd;
        e.data  = 32'h0;
        e.smin  = (rd && wr) ? 0 : SMIN[k];
        e.smax  = (rd && wr) ? 0 : SMAX[k];
        if (rd && wr) begin
            err_m[k] = 1'b1;
        end else begin
            if (!hit_m(a) || (a[1:0] != 2'b00)) err_m[k] = 1'b1;
            if (rd && hit_m(a)) e.data = mem_m.exists(key) ? mem_m[key] : 32'h0;
            if (wr && hit_m(a)) begin
                word = mem_m.exists(key) ? mem_m[key] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                end
                mem_m[key] = word;
            end
        end
        cnt_m[k]++;
        exp_q.push_back(e);
        sel        = 2'(k);
        address    = a;
        read       = rd;
        write      = wr;
        byteenable = be;
        writedata  = wd;
        budget     = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (m_wait && budget < 20);
        if (m_wait) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xfer_timeout: inst %0d addr %h still waiting after %0d cycles", k, a, budget);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic check_status(input int k, input string tag);
        check($sformatf("%s_xfer_count[%0d]", tag, k), 32'(xc_v[k]), 32'(cnt_m[k] % 65536));
        check($sformatf("%s_err[%0d]", tag, k), 32'(err_v[k]), 32'(err_m[k]));
    endtask

    initial begin
        logic [31:0] a;
        for (int k = 0; k < N_DUT; k++) begin
            cnt_m[k] = 0;
            err_m[k] = 1'b0;
        end

        // Reset: a pending request must not raise waitrequest while reset is low.
        sel     = 2'd1;
        address = BOOT;
        read    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(wait_v[1]), 32'h0);
        check("rst_readdata", rdat_v[1], 32'h0);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check_status(k, "reset");
            check($sformatf("reset_wait[%0d]", k), 32'(wait_v[k]), 32'h0);
        end

        // Zero-wait write then read back.
        do_xfer(0, 1'b0, 1'b1, 32'h190, 4'hF, 32'hDEADBEEF);
        do_xfer(0, 1'b1, 1'b0, 32'h190, 4'h0, 32'h0);
        check_status(0, "t1");

        // Byte-lane masking.
        do_xfer(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        do_xfer(0, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        do_xfer(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        do_xfer(0, 1'b0, 1'b1, 32'h1FFC, 4'hF, 32'h5EED1234);
        do_xfer(0, 1'b1, 1'b0, 32'h1FFC, 4'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            do_xfer(0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_xfer(0, 1'b0, 1'b1, a, 4'($urandom_range(0, 15)), $urandom);
            else
                do_xfer(0, 1'b1, 1'b0, a, 4'h0, 32'h0);
        end
        check_status(0, "t2");

        // Boot region with three wait states.
        do_xfer(1, 1'b0, 1'b1, BOOT, 4'hF, 32'h8C010064);
        do_xfer(1, 1'b1, 1'b0, BOOT, 4'h0, 32'h0);
        do_xfer(1, 1'b0, 1'b1, BOOT + 32'h7FC, 4'hF, 32'h0F0F1234);
        do_xfer(1, 1'b1, 1'b0, BOOT + 32'h7FC, 4'h0, 32'h0);
        check_status(1, "t3");

        // Random-wait instance: preload words before the mid-test reset.
        for (int i = 0; i < 32; i++) begin
            do_xfer(3, 1'b0, 1'b1, 32'h800 + 32'(4 * i), 4'hF, $urandom);
        end

        // Reset in the second wait cycle of a five-wait write abandons it.
        do_xfer(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        sel        = 2'd2;
        address    = 32'h40;
        byteenable = 4'hF;
        writedata  = 32'h12345678;
        write      = 1'b1;
        @(negedge clk);
        check("t5_wait_cycle1", 32'(m_wait), 32'h1);
        @(negedge clk);
        check("t5_wait_cycle2", 32'(m_wait), 32'h1);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            cnt_m[k] = 0;
            err_m[k] = 1'b0;
            check_status(k, "t5_in_reset");
        end
        check("t5_waitrequest", 32'(m_wait), 32'h0);
        check("t5_readdata", m_rdata, 32'h0);
        write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_xfer(2, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        check_status(2, "t5_after");

        // Error cases: simultaneous read/write, decode miss, misaligned access.
        do_xfer(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0BADCAFE);
        check_status(0, "t4_clean");
        do_xfer(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFFFFFF);
        check_status(0, "t4_rw");
        do_xfer(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        do_xfer(0, 1'b1, 1'b0, 32'h10000000, 4'h0, 32'h0);
        do_xfer(0, 1'b0, 1'b1, 32'h2000, 4'hF, 32'h77777777);
        do_xfer(0, 1'b1, 1'b0, 32'h22, 4'h0, 32'h0);
        do_xfer(0, 1'b1, 1'b0, 32'h1FFC, 4'h0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check_status(0, "t4_sticky");

        // Back-to-back reads with pseudo-random wait states.
        for (int i = 0; i < 1000; i++) begin
            do_xfer(3, 1'b1, 1'b0, 32'h800 + 32'(4 * $urandom_range(0, 31)), 4'h0, 32'h0);
        end
        check_status(3, "t6");

        repeat (2) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
